// File: rtl/aidc_lite_pkg.sv
// Shared types and constants for the AIDC-lite compressor scheduling slice.
package aidc_lite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } sched_state_e;

  localparam int AIDC_BEAT_W = 64;
  localparam int AIDC_ADDR_W = 4;

  // Even beat counts keep the compressed output within a 4-bit word address.
  function automatic bit beats_legal(input int beats);
    return (beats >= 2) && (beats <= 32) && ((beats % 2) == 0);
  endfunction

endpackage

// File: rtl/aidc_lite_comp_sched_if.sv
// Source, compressor and response signals of the compressor scheduler.
interface aidc_lite_comp_sched_if
  import aidc_lite_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                  req_i;
  logic [NUM_REQ-1:0]                  gnt_o;
  logic [NUM_REQ-1:0]                  src_valid_i;
  logic [NUM_REQ-1:0][AIDC_BEAT_W-1:0] src_data_i;
  logic [NUM_REQ-1:0]                  src_ready_o;
  logic                                comp_valid_o;
  logic                                comp_sop_o;
  logic                                comp_eop_o;
  logic [AIDC_BEAT_W-1:0]              comp_data_o;
  logic                                comp_done_i;
  logic                                comp_fail_i;
  logic [ID_W-1:0]                     owner_o;
  logic                                rsp_valid_o;
  logic [ID_W-1:0]                     rsp_id_o;
  logic                                rsp_fail_o;

  modport master (
    output req_i, src_valid_i, src_data_i, comp_done_i, comp_fail_i,
    input  gnt_o, src_ready_o, comp_valid_o, comp_sop_o, comp_eop_o, comp_data_o,
    input  owner_o, rsp_valid_o, rsp_id_o, rsp_fail_o
  );

  modport slave (
    input  req_i, src_valid_i, src_data_i, comp_done_i, comp_fail_i,
    output gnt_o, src_ready_o, comp_valid_o, comp_sop_o, comp_eop_o, comp_data_o,
    output owner_o, rsp_valid_o, rsp_id_o, rsp_fail_o
  );

endinterface

// File: rtl/aidc_lite_rr_arb.sv
// Combinational round-robin pick; the search starts at ptr and wraps.
module aidc_lite_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    id,
  output logic               hit
);

  always_comb begin
    int cand;
    gnt  = '0;
    id   = '0;
    hit  = 1'b0;
    cand = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (!hit && req[cand]) begin
        hit       = 1'b1;
        gnt[cand] = 1'b1;
        id        = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/aidc_lite_comp_sched.sv
// Shares one sign-reduction compressor among NUM_REQ block sources:
// round-robin grant, BEATS-beat stream with sop/eop, wait for done, respond.
module aidc_lite_comp_sched
  import aidc_lite_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int BEATS   = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  aidc_lite_comp_sched_if.slave bus
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BEATS);

  if (!beats_legal(BEATS) || (NUM_REQ < 2) || (NUM_REQ > 8)) begin : g_param_chk
    $error("aidc_lite_comp_sched: BEATS must be even in 2..32 and NUM_REQ in 2..8");
  end

  sched_state_e           state;
  logic [NUM_REQ-1:0]     gnt_q;
  logic [ID_W-1:0]        ptr_q;
  logic [ID_W-1:0]        owner_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   rsp_valid_q;
  logic [ID_W-1:0]        rsp_id_q;
  logic                   rsp_fail_q;

  logic [NUM_REQ-1:0]     arb_gnt;
  logic [ID_W-1:0]        arb_id;
  logic                   arb_hit;

  logic                   beat_acc_p0;
  logic                   beat_last_p0;
  logic                   vld_p1;
  logic                   sop_p1;
  logic                   eop_p1;
  logic [AIDC_BEAT_W-1:0] data_p1;

  aidc_lite_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req (bus.req_i),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .id  (arb_id),
    .hit (arb_hit)
  );

  // Stage p0: beat accept from the granted source; ready comes from state only.
  assign beat_acc_p0  = (state == ST_STREAM) && bus.src_valid_i[owner_q];
  assign beat_last_p0 = (cnt_q == CNT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      gnt_q       <= '0;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_fail_q  <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_hit && bus.comp_done_i) begin
            gnt_q   <= arb_gnt;
            owner_q <= arb_id;
            cnt_q   <= '0;
            state   <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (beat_acc_p0) begin
            cnt_q <= cnt_q + 1'b1;
            if (beat_last_p0) begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (bus.comp_done_i) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= owner_q;
            rsp_fail_q  <= bus.comp_fail_i;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          gnt_q <= '0;
          ptr_q <= (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage p1: registered copy of the accepted beat toward the compressor.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      sop_p1 <= 1'b0;
      eop_p1 <= 1'b0;
    end else begin
      vld_p1 <= beat_acc_p0;
      sop_p1 <= beat_acc_p0 && (cnt_q == '0);
      eop_p1 <= beat_acc_p0 && beat_last_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_acc_p0) begin
      data_p1 <= bus.src_data_i[owner_q];
    end
  end

  assign bus.gnt_o        = gnt_q;
  assign bus.src_ready_o  = (state == ST_STREAM) ? gnt_q : '0;
  assign bus.comp_valid_o = vld_p1;
  assign bus.comp_sop_o   = sop_p1;
  assign bus.comp_eop_o   = eop_p1;
  assign bus.comp_data_o  = data_p1;
  assign bus.owner_o      = owner_q;
  assign bus.rsp_valid_o  = rsp_valid_q;
  assign bus.rsp_id_o     = rsp_id_q;
  assign bus.rsp_fail_o   = rsp_fail_q;

endmodule

// File: tb/tb_aidc_lite_comp_sched.sv
// Scoreboard bench for aidc_lite_comp_sched with a behavioural source/compressor agent.
module tb_aidc_lite_comp_sched;
  import aidc_lite_pkg::*;

  localparam int NR    = 4;
  localparam int BEATS = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aidc_lite_comp_sched_if #(.NUM_REQ(NR)) bus ();

  aidc_lite_comp_sched #(
    .NUM_REQ (NR),
    .BEATS   (BEATS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { logic [63:0] data; logic sop; logic eop; } beat_t;
  typedef struct { int id; logic fail; int cyc; } rsp_t;

  beat_t         beat_q[$];
  rsp_t          rsp_q[$];
  int            bad_q[NR][$];   // per-source pending blocks: bad beat index or -1
  logic [NR-1:0] gnt_log[$];
  int            idx[NR];
  int            seq[NR];
  int            gap_at[NR];
  int            gap_left[NR];
  int            cyc, ntot, nbad, vld_cnt, eop_cnt, n_rsp;
  bit            hold, done_nx, fail_nx, acc_bad, rsp_prev;
  logic [NR-1:0] gnt_prev;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_beat(input int s, input int sq, input int b, input int bad_beat);
    logic [63:0] d;
    logic [7:0]  v;
    d = '0;
    for (int l = 0; l < 4; l++) begin
      v = 8'((s * 37 + sq * 11 + b * 5 + l * 3) ^ 'h5A);
      d[l*16 +: 16] = {{8{v[7]}}, v};
    end
    if (b == bad_beat) d[15:0] = 16'h0180;
    return d;
  endfunction

  function automatic bit lane_bad(input logic [63:0] d);
    for (int l = 0; l < 4; l++) begin
      if (d[l*16+8 +: 8] != {8{d[l*16+7]}}) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int oh_idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic monitor();
    beat_t eb;
    rsp_t  er;
    if (bus.comp_valid_o) begin
      vld_cnt++;
      if (bus.comp_eop_o) eop_cnt++;
      if (beat_q.size() == 0) begin
        chk("beat_extra", 64'(bus.comp_valid_o), 64'd0);
      end else begin
        eb = beat_q.pop_front();
        chk("beat_data", bus.comp_data_o, eb.data);
        chk("beat_sop", 64'(bus.comp_sop_o), 64'(eb.sop));
        chk("beat_eop", 64'(bus.comp_eop_o), 64'(eb.eop));
      end
    end else begin
      chk("idle_sop_eop", 64'({bus.comp_sop_o, bus.comp_eop_o}), 64'd0);
    end
    if (bus.rsp_valid_o) begin
      n_rsp++;
      if (rsp_q.size() == 0) begin
        chk("rsp_extra", 64'(bus.rsp_valid_o), 64'd0);
      end else begin
        er = rsp_q.pop_front();
        chk("rsp_id", 64'(bus.rsp_id_o), 64'(er.id));
        chk("rsp_fail", 64'(bus.rsp_fail_o), 64'(er.fail));
        chk("rsp_latency", 64'(cyc - er.cyc), 64'd2);
        chk("rsp_gnt_held", 64'(bus.gnt_o), 64'(1 << er.id));
      end
    end
    chk("gnt_onehot", 64'($onehot0(bus.gnt_o)), 64'd1);
    chk("rdy_in_gnt", 64'(bus.src_ready_o & ~bus.gnt_o), 64'd0);
    if ((bus.gnt_o != '0) && (gnt_prev == '0)) begin
      gnt_log.push_back(bus.gnt_o);
      chk("owner", 64'(bus.owner_o), 64'(oh_idx(bus.gnt_o)));
      chk("gnt_after_rsp", 64'(rsp_prev), 64'd0);
    end
    gnt_prev = bus.gnt_o;
    rsp_prev = bus.rsp_valid_o;
  endtask

  task automatic model_and_drive();
    logic [NR-1:0]        req, vld;
    logic [NR-1:0][63:0]  dat;
    if (!rst_n) begin
      done_nx = 1'b1;
      fail_nx = 1'b0;
      acc_bad = 1'b0;
    end
    // compressor: registered response to the beat seen this cycle
    bus.comp_done_i = done_nx & ~hold;
    bus.comp_fail_i = fail_nx;
    if (rst_n && bus.comp_valid_o) begin
      if (bus.comp_sop_o) begin
        done_nx = 1'b0;
        acc_bad = 1'b0;
      end
      acc_bad = acc_bad | lane_bad(bus.comp_data_o);
      if (bus.comp_eop_o) begin
        done_nx = 1'b1;
        fail_nx = acc_bad;
      end
    end
    req = '0;
    vld = '0;
    dat = '0;
    for (int s = 0; s < NR; s++) begin
      if (bad_q[s].size() != 0) begin
        req[s] = 1'b1;
        if ((idx[s] == gap_at[s]) && (gap_left[s] > 0)) begin
          gap_left[s]--;
        end else begin
          vld[s] = 1'b1;
          dat[s] = mk_beat(s, seq[s], idx[s], bad_q[s][0]);
        end
      end
    end
    bus.req_i       = req;
    bus.src_valid_i = vld;
    bus.src_data_i  = dat;
  endtask

  initial begin : agent
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n) begin
        for (int s = 0; s < NR; s++) begin
          if (bus.src_valid_i[s] && bus.src_ready_o[s] && (bad_q[s].size() != 0)) begin
            beat_q.push_back('{bus.src_data_i[s], idx[s] == 0, idx[s] == BEATS - 1});
            if (idx[s] == BEATS - 1) begin
              rsp_q.push_back('{s, bad_q[s][0] >= 0, cyc});
              void'(bad_q[s].pop_front());
              idx[s] = 0;
              seq[s]++;
            end else begin
              idx[s]++;
            end
          end
        end
      end
      @(negedge clk);
      if (rst_n) monitor();
      model_and_drive();
    end
  end

  task automatic wait_drain(input int maxc);
    int n;
    bit busy;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      busy = (beat_q.size() != 0) || (rsp_q.size() != 0) || (bus.gnt_o != '0);
      for (int s = 0; s < NR; s++) if (bad_q[s].size() != 0) busy = 1'b1;
    end while (busy && (n < maxc));
    chk("drain_timeout", 64'(busy), 64'd0);
    @(negedge clk);
  endtask

  task automatic flush();
    beat_q.delete();
    rsp_q.delete();
    for (int s = 0; s < NR; s++) begin
      bad_q[s].delete();
      idx[s] = 0;
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_gnt"}, 64'(bus.gnt_o), 64'd0);
    chk({pfx, "_rdy"}, 64'(bus.src_ready_o), 64'd0);
    chk({pfx, "_cvld"}, 64'(bus.comp_valid_o), 64'd0);
    chk({pfx, "_sop"}, 64'(bus.comp_sop_o), 64'd0);
    chk({pfx, "_eop"}, 64'(bus.comp_eop_o), 64'd0);
    chk({pfx, "_rvld"}, 64'(bus.rsp_valid_o), 64'd0);
    chk({pfx, "_rfail"}, 64'(bus.rsp_fail_o), 64'd0);
    chk({pfx, "_owner"}, 64'(bus.owner_o), 64'd0);
    chk({pfx, "_rid"}, 64'(bus.rsp_id_o), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    flush();
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin : main
    logic [NR-1:0] exp_order[5];
    int            n;
    hold = 1'b0; done_nx = 1'b1; fail_nx = 1'b0; acc_bad = 1'b0;
    rsp_prev = 1'b0; gnt_prev = '0;
    cyc = 0; ntot = 0; nbad = 0; vld_cnt = 0; eop_cnt = 0; n_rsp = 0;
    for (int s = 0; s < NR; s++) begin
      idx[s] = 0; seq[s] = 0; gap_at[s] = -1; gap_left[s] = 0;
    end
    bus.req_i = '0; bus.src_valid_i = '0; bus.src_data_i = '0;
    bus.comp_done_i = 1'b1; bus.comp_fail_i = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    // single source, good block
    @(negedge clk);
    n_rsp = 0;
    bad_q[0].push_back(-1);
    wait_drain(200);
    chk("single_rsps", 64'(n_rsp), 64'd1);

    // fail path then clean block from the same source
    n_rsp = 0;
    bad_q[0].push_back(3);
    bad_q[0].push_back(-1);
    wait_drain(400);
    chk("fail_rsps", 64'(n_rsp), 64'd2);

    // contention from pointer 0
    do_reset();
    gnt_log.delete();
    bad_q[0].push_back(-1);
    bad_q[0].push_back(-1);
    bad_q[1].push_back(-1);
    bad_q[2].push_back(-1);
    bad_q[3].push_back(-1);
    wait_drain(1000);
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    chk("cont_grants", 64'(gnt_log.size()), 64'd5);
    n = (gnt_log.size() < 5) ? gnt_log.size() : 5;
    for (int i = 0; i < n; i++) chk("cont_order", 64'(gnt_log[i]), 64'(exp_order[i]));

    // valid gaps mid-block
    vld_cnt = 0; eop_cnt = 0;
    gap_at[2] = 6; gap_left[2] = 5;
    bad_q[2].push_back(-1);
    wait_drain(300);
    chk("gap_vld_cnt", 64'(vld_cnt), 64'(BEATS));
    chk("gap_eop_cnt", 64'(eop_cnt), 64'd1);

    // done gating in IDLE
    hold = 1'b1;
    bus.comp_done_i = 1'b0;
    @(negedge clk);
    bad_q[1].push_back(-1);
    repeat (5) @(negedge clk);
    chk("gate_gnt", 64'(bus.gnt_o), 64'd0);
    chk("gate_rdy", 64'(bus.src_ready_o), 64'd0);
    hold = 1'b0;
    bus.comp_done_i = done_nx;
    @(negedge clk);
    chk("gate_release_gnt", 64'(bus.gnt_o), 64'b0010);
    wait_drain(300);

    // reset mid-STREAM after beat 7
    bad_q[3].push_back(-1);
    n = 0;
    while ((idx[3] < 8) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reach_beat8", 64'(idx[3]), 64'd8);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("mid");
    flush();
    @(negedge clk);
    rst_n = 1'b1;
    gnt_log.delete();
    bad_q[1].push_back(-1);
    bad_q[2].push_back(-1);
    wait_drain(600);
    chk("post_rst_grants", 64'(gnt_log.size()), 64'd2);
    if (gnt_log.size() >= 2) begin
      chk("post_rst_first", 64'(gnt_log[0]), 64'b0010);
      chk("post_rst_second", 64'(gnt_log[1]), 64'b0100);
    end

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule
